master_rx_ctrl: RTL

- Sequences one master_in_port receive transaction per host request.
- Latches instruction and burst size, holds the port's s_valid/instruction/burst_size for the whole burst, and counts received words against the expected count.
- Buffers words in a small FIFO, because the port cannot be back-pressured, and presents them to the host as a valid/ready stream.
- Detects timeout, overflow and word-count errors; sits between the bus-master control logic and master_in_port.

---
 rtl/master_pkg.sv | 6 +
 rtl/rx_word_fifo.sv | 41 ++++
 rtl/master_rx_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/master_pkg.sv
// master_pkg: shared instruction codes and receive-controller state type
package master_pkg;
    localparam logic [2:0] INSTR_NOP  = 3'b000;
    localparam logic [2:0] INSTR_READ = 3'b001;
    typedef enum logic [1:0] {IDLE, RECV, DRAIN, ABORT} rx_ctrl_state_t;
endpackage

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: registered word buffer; push into a full FIFO only succeeds with a same-cycle pop
module rx_word_fifo #(
    parameter int WORD_SIZE  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] pop_data,
    output logic                 empty,
    output logic                 full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign empty    = count == '0;
    assign full     = count == (AW+1)'(FIFO_DEPTH);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];
    // pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage needs no reset: contents are meaningless while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/master_rx_ctrl.sv
// master_rx_ctrl: sequences one master_in_port receive burst per request and streams words to the host
module master_rx_ctrl
    import master_pkg::*;
#(
    parameter int WORD_SIZE      = 8,
    parameter int BURST_SIZE     = 15,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_instr,
    input  logic [BURST_SIZE-1:0] req_burst,
    output logic                  port_s_valid,
    output logic [2:0]            port_instruction,
    output logic [BURST_SIZE-1:0] port_burst_size,
    output logic                  port_clr,
    input  logic                  port_new_data,
    input  logic [WORD_SIZE-1:0]  port_s_data,
    input  logic                  port_rx_done,
    output logic [WORD_SIZE-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  err_overflow,
    output logic                  err_count
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    rx_ctrl_state_t state, state_nx;
    logic [2:0] instr_q;
    logic [BURST_SIZE:0] expected, word_cnt, cnt_after;
    logic [WD_W-1:0] wd;
    logic empty, full, accept, strobe, excess, push, pop, timeout_hit;
    assign accept      = req_valid && state == IDLE;
    assign strobe      = state == RECV && port_new_data;
    assign excess      = word_cnt == expected;
    assign push        = strobe && !excess;
    assign pop         = !empty && m_ready;
    assign m_valid     = !empty;
    assign cnt_after   = word_cnt + {{BURST_SIZE{1'b0}}, push};
    assign timeout_hit = !port_new_data && wd == WD_W'(TIMEOUT_CYCLES - 1);

    rx_word_fifo #(.WORD_SIZE(WORD_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (port_s_data),
        .pop       (pop),
        .pop_data  (m_data),
        .empty     (empty),
        .full      (full)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: rx_done beats a same-cycle watchdog expiry
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? RECV : IDLE;
            RECV:    state_nx = port_rx_done ? DRAIN : timeout_hit ? ABORT : RECV;
            DRAIN:   state_nx = empty ? IDLE : DRAIN;
            default: state_nx = DRAIN;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        req_ready        = state == IDLE;
        busy             = state != IDLE;
        port_s_valid     = state == RECV;
        port_instruction = state == RECV ? instr_q : INSTR_NOP;
        port_clr         = state == ABORT;
        done             = state == DRAIN && empty;
    end

    // request latching, word/watchdog counters and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q         <= INSTR_NOP;
            port_burst_size <= '0;
            expected        <= '0;
            word_cnt        <= '0;
            wd              <= '0;
            err_timeout     <= 1'b0;
            err_overflow    <= 1'b0;
            err_count       <= 1'b0;
        end else if (accept) begin
            instr_q         <= req_instr;
            port_burst_size <= req_burst;
            expected        <= {1'b0, req_burst} + 1'b1;
            word_cnt        <= '0;
            wd              <= '0;
            err_timeout     <= 1'b0;
            err_overflow    <= 1'b0;
            err_count       <= 1'b0;
        end else if (state == RECV) begin
            wd       <= port_new_data ? '0 : wd + 1'b1;
            word_cnt <= cnt_after;
            if ((strobe && excess) || (port_rx_done && cnt_after != expected)) err_count <= 1'b1;
            if (push && full && !pop) err_overflow <= 1'b1;
            if (timeout_hit && !port_rx_done) err_timeout <= 1'b1;
        end
    end
endmodule
